// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with a
// per-register pending-write (busy) scoreboard.
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   rd_addr_i    NUM_RD read addresses, port k at [k*AW +: AW]
//   rd_data_o    NUM_RD read data words, combinational
//   rd_busy_o    per read port: a write to the addressed register is pending
//   wr_en_i      NUM_WR write enables
//   wr_addr_i    NUM_WR write addresses
//   wr_data_i    NUM_WR write data words
//   iss_en_i     an instruction with a destination register issues
//   iss_addr_i   destination register of the issuing instruction
//   flush_i      clears every busy bit
//   busy_vec_o   registered busy bits
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data (and the resulting busy clear) to the read ports.

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic [NUM_WR*$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
  input  logic                       iss_en_i,
  input  logic [$clog2(DEPTH)-1:0]   iss_addr_i,
  input  logic                       flush_i,
  output logic [DEPTH-1:0]           busy_vec_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] reg_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // Per-register write resolution: which registers are written this cycle and with what.
  logic [DEPTH-1:0]  wr_hit_s;
  logic [DATA_W-1:0] wr_val_s [DEPTH];

  // Resolve write ports per register; later (higher-index) ports override earlier ones.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      wr_hit_s[r] = 1'b0;
      wr_val_s[r] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == AW'(r))) begin
          wr_hit_s[r] = 1'b1;
          wr_val_s[r] = wr_data_i[j*DATA_W +: DATA_W];
        end else begin
          wr_hit_s[r] = wr_hit_s[r];
        end
      end
      // A hardwired zero register swallows writes.
      if ((ZERO_REG == 1) && (r == 0)) begin
        wr_hit_s[r] = 1'b0;
      end else begin
        wr_hit_s[r] = wr_hit_s[r];
      end
    end
  end

  // Busy next state: flush beats issue, issue beats writeback (writeback
  // belongs to an older producer), writeback beats hold.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      if (flush_i) begin
        busy_d[r] = 1'b0;
      end else if (iss_en_i && (iss_addr_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit_s[r]) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
      if ((ZERO_REG == 1) && (r == 0)) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_d[r];
      end
    end
  end

  // Register array and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        reg_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit_s[r]) begin
          reg_q[r] <= wr_val_s[r];
        end
      end
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

  // Combinational read ports.
  logic [AW-1:0] rd_a_s;
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    rd_a_s    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_a_s = rd_addr_i[k*AW +: AW];
      rd_data_o[k*DATA_W +: DATA_W] = reg_q[rd_a_s];
      rd_busy_o[k]                  = busy_q[rd_a_s];
`ifdef REGFILE_BYPASS_EN
      // Forward the winning same-cycle write; it also retires the pending write.
      if (wr_hit_s[rd_a_s]) begin
        rd_data_o[k*DATA_W +: DATA_W] = wr_val_s[rd_a_s];
        rd_busy_o[k]                  = 1'b0;
      end else begin
        rd_busy_o[k] = rd_busy_o[k];
      end
`endif
      // Zero register and held reset override everything, including bypass.
      if (((ZERO_REG == 1) && (rd_a_s == '0)) || rst) begin
        rd_data_o[k*DATA_W +: DATA_W] = '0;
        rd_busy_o[k]                  = 1'b0;
      end else begin
        rd_busy_o[k] = rd_busy_o[k];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int D  = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  logic               clk;
  logic               rst;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_busy;
  logic [NW-1:0]      wr_en;
  logic [NW*AW-1:0]   wr_addr;
  logic [NW*DW-1:0]   wr_data;
  logic               iss_en;
  logic [AW-1:0]      iss_addr;
  logic               flush;
  logic [D-1:0]       busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp #(.DATA_W(DW), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .flush_i    (flush),
    .busy_vec_o (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    flush    = 1'b0;
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data);
    wr_en[port]               = 1'b1;
    wr_addr[port*AW +: AW]    = addr[AW-1:0];
    wr_data[port*DW +: DW]    = data;
  endtask

  task automatic iss(input int addr);
    iss_en   = 1'b1;
    iss_addr = addr[AW-1:0];
  endtask

  // Set a read address and let the combinational path settle.
  task automatic rd(input int port, input int addr);
    rd_addr[port*AW +: AW] = addr[AW-1:0];
    #1;
  endtask

  function automatic logic [31:0] rdata(input int port);
    return rd_data[port*DW +: DW];
  endfunction

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy_vec", busy_vec, 32'h0);
    rd(0, 5);
    check_eq("reset_rd_data", rdata(0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Write x5, then issue x5 so reset has state to wipe.
    wr(0, 5, 32'hDEADBEEF);
    tick();
    idle();
    iss(5);
    tick();
    idle();
    rd(0, 5);
    check_eq("x5_written", rdata(0), 32'hDEADBEEF);
    check_eq("x5_busy_vec", busy_vec, 32'h0000_0020);
    check_eq("x5_rd_busy", rd_busy[0], 1'b1);
    // Asynchronous reset mid-cycle: outputs clear with no clock edge.
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_data", rdata(0), 32'h0);
    check_eq("async_rst_busy_vec", busy_vec, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    rd(0, 5);
    check_eq("post_rst_x5", rdata(0), 32'h0);

    // Write collision: highest-index port wins.
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    tick();
    idle();
    rd(1, 7);
    check_eq("collision_x7", rdata(1), 32'h22);

    // Independent writes on both ports, read on both ports.
    wr(0, 8, 32'h100);
    wr(1, 10, 32'h200);
    tick();
    idle();
    rd(0, 8);
    rd(1, 10);
    check_eq("dual_wr_x8", rdata(0), 32'h100);
    check_eq("dual_wr_x10", rdata(1), 32'h200);

    // x0 ignores writes and issue.
    wr(0, 0, 32'hFFFFFFFF);
    wr(1, 0, 32'hFFFFFFFF);
    iss(0);
    rd(0, 0);
    rd(1, 0);
    check_eq("x0_same_cycle_data", rdata(0), 32'h0);
    tick();
    idle();
    check_eq("x0_data_p0", rdata(0), 32'h0);
    check_eq("x0_data_p1", rdata(1), 32'h0);
    check_eq("x0_busy", {30'h0, rd_busy}, 32'h0);
    check_eq("x0_busy_vec", busy_vec, 32'h0);

    // Scoreboard: issue x3 in cycle 0, busy from cycle 1.
    iss(3);
    tick();
    idle();
    rd(1, 3);
    check_eq("x3_busy_c1", rd_busy[1], 1'b1);
    tick();
    tick();
    tick();
    // Cycle 4: writeback x3 = 0x55.
    wr(1, 3, 32'h55);
    rd(0, 3);
`ifdef REGFILE_BYPASS_EN
    check_eq("x3_wb_c4_busy", rd_busy[0], 1'b0);
    check_eq("x3_wb_c4_data", rdata(0), 32'h55);
`else
    check_eq("x3_wb_c4_busy", rd_busy[0], 1'b1);
    check_eq("x3_wb_c4_data", rdata(0), 32'h0);
`endif
    tick();
    idle();
    check_eq("x3_c5_busy", rd_busy[0], 1'b0);
    check_eq("x3_c5_data", rdata(0), 32'h55);

    // Issue-vs-writeback race on x9.
    iss(9);
    tick();
    idle();
    rd(0, 9);
    check_eq("x9_busy", rd_busy[0], 1'b1);
    iss(9);
    wr(0, 9, 32'hA5);
    tick();
    idle();
    check_eq("race_x9_busy", rd_busy[0], 1'b1);
    check_eq("race_x9_data", rdata(0), 32'hA5);

    // Flush with a same-cycle issue clears everything.
    iss(1);
    tick();
    iss(2);
    tick();
    iss(4);
    tick();
    idle();
    check_eq("pre_flush_busy_vec", busy_vec, 32'h0000_0216);
    flush = 1'b1;
    iss(6);
    tick();
    idle();
    check_eq("flush_busy_vec", busy_vec, 32'h0);

    // Plain writeback clears a single busy bit.
    iss(12);
    tick();
    idle();
    wr(1, 12, 32'h1234);
    tick();
    idle();
    check_eq("wb_clear_busy_vec", busy_vec, 32'h0);
    rd(1, 12);
    check_eq("wb_x12_data", rdata(1), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register pending-write scoreboard, for the Buceros core. It replaces the fixed 2-read/1-write register file for wider issue configurations. It has NUM_RD combinational read ports and NUM_WR synchronous write ports, and register 0 can be hardwired to zero. A busy bit per register is set when an instruction issues with that register as destination and cleared on writeback, so decode can detect RAW hazards without an external scoreboard.

## Interface
- DATA_W, 32: register width in bits.
- DEPTH, 32: number of registers; must be a power of two, ≥ 2. AW = $clog2(DEPTH).
- NUM_RD, 2: number of read ports, 1..8.
- NUM_WR, 2: number of write ports, 1..4.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes and is never busy; 0 = register 0 is ordinary.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr_i  in  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data_o  out  NUM_RD*DATA_W  read data, combinational.
- rd_busy_o  out  NUM_RD  1 = a write to the addressed register is still pending.
- wr_en_i  in  NUM_WR  write enables, one per port.
- wr_addr_i  in  NUM_WR*AW  write addresses.
- wr_data_i  in  NUM_WR*DATA_W  write data.
- iss_en_i  in  1  an instruction with a destination register issues this cycle.
- iss_addr_i  in  AW  destination register of the issuing instruction.
- flush_i  in  1  clears every busy bit (pipeline flush).
- busy_vec_o  out  DEPTH  registered busy bits, for debug and trace.

## Operation
- Storage: reg_q[DEPTH], busy_q[DEPTH].
- Reset (rst=1, asynchronous): all reg_q = 0 and all busy_q = 0. While reset is held, rd_data_o = 0, rd_busy_o = 0 and busy_vec_o = 0.
- Write, per rising edge: for each register r, take the highest-index port j with wr_en_i[j] and wr_addr_i[j] == r. That port's data is written; lower-index colliding ports are discarded.
- Writes to register 0 are dropped when ZERO_REG = 1.
- Scoreboard, next-state of busy_q[r], in priority order:
  1. flush_i → 0.
  2. iss_en_i and iss_addr_i == r → 1. Issue wins over a same-cycle writeback to r, because the writeback belongs to the older producer.
  3. Any write port hits r → 0.
  4. Otherwise hold.
- flush_i and iss_en_i in the same cycle: flush clears all bits, including the issued register.
- With ZERO_REG = 1, busy_q[0] is constant 0.
- Read port k, addressed register a:
  - a == 0 and ZERO_REG = 1 → data 0, busy 0.
  - Otherwise, data = reg_q[a] and busy = busy_q[a]. Bypass, when enabled, modifies this (see Configuration).
- Out-of-range addresses cannot occur because DEPTH is a power of two.

## Timing
- Read latency: 0 cycles, purely combinational from rd_addr_i.
- Write latency: 1 cycle. Data is visible from the array on the cycle after wr_en_i.
- Scoreboard latency:
  - busy_q set by issue in cycle t reads 1 from cycle t+1.
  - busy_q cleared by writeback in cycle t reads 0 from cycle t+1, or in cycle t with bypass.
- Reset is asynchronous on assert. Release is synchronous to clk in the surrounding design, and the block needs no internal synchronisation.
- Reset mid-operation discards any pending writes and all busy state.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Read ports forward same-cycle write data. If any write port hits the addressed register, rd_data_o returns the highest-index hitting port's wr_data_i, and rd_busy_o = 0.
  - rd_busy_o remains 1 only if busy_q is set and no write hits the register this cycle.
  - The ZERO_REG rule still takes precedence.
- Not defined:
  - rd_data_o = reg_q[a] and rd_busy_o = busy_q[a].
  - No combinational path from wr_* or iss_* to the read outputs.
  - The consumer must wait one cycle after writeback.

## Test plan
- Reset, ZERO_REG = 1: assert rst mid-run after writing x5 = 0xDEADBEEF → rd_data_o = 0 and busy_vec_o = 0 immediately, without waiting for a clk edge. Release, then read x5 → 0.
- Write collision: wr_en_i = 2'b11, both ports address x7, data 0x11 (port 0) and 0x22 (port 1) → next cycle x7 reads 0x22.
- x0: write 0xFFFFFFFF to x0 and issue x0 → reads 0 and rd_busy_o = 0 on every port.
- Scoreboard:
  - Issue x3 in cycle 0 → rd_busy_o = 1 for x3 in cycle 1.
  - Writeback x3 = 0x55 in cycle 4 → with bypass, busy = 0 and data = 0x55 in cycle 4; without bypass, same values in cycle 5.
- Issue-vs-writeback race: x9 busy; in one cycle, issue x9 and write back x9 = 0xA5 → next cycle busy = 1 and data = 0xA5.
- Flush: issue x1, x2, x4 over 3 cycles, then flush_i together with issue of x6 → next cycle busy_vec_o = 0.
